// File: rtl/aes_inv_cipher_ctrl.sv
// aes_inv_cipher_ctrl: iterative AES inverse cipher, one round per clock over a shared datapath.
// Define AES_INV_CIPHER_ABORT_EN to let abort flush an in-flight or pending block.
module aes_inv_cipher_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_key,
  output logic         busy,
  input  logic         abort
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} st_e;
  st_e st_q, st_d;
  logic [3:0] cnt_q, cnt_d;
  logic [127:0] s_q, s_d, o_q, o_d;
  logic [127:0] sr_sb, rnd;
  logic accept;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse affine map followed by the GF(2^8) inverse computed as y^254.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] y, r;
    y = {b[6:0], b[7]} ^ {b[1:0], b[7:2]} ^ {b[4:0], b[7:5]} ^ 8'h05;
    r = y;
    for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), y);
    return gmul(r, r);
  endfunction

  function automatic logic [127:0] isr_isb(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  assign sr_sb     = isr_isb(s_q) ^ rk_key;
  assign rnd       = inv_mix(sr_sb);
  assign in_ready  = !rst && (st_q == IDLE || (st_q == DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = st_q == DONE;
  assign out_data  = o_q;
  assign busy      = st_q == ROUND || st_q == FINAL;
  assign rk_idx    = st_q == ROUND ? cnt_q : st_q == FINAL ? 4'd0 : 4'(NR);

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    s_d   = s_q;
    o_d   = o_q;
    case (st_q)
      IDLE, DONE: begin
        if (st_q == IDLE || out_ready) st_d = IDLE;
        if (accept) begin
          s_d   = in_data ^ rk_key;
          cnt_d = 4'(NR - 1);
          st_d  = ROUND;
        end
      end
      ROUND: begin
        s_d   = rnd;
        cnt_d = cnt_q == 4'd1 ? cnt_q : cnt_q - 4'd1;
        st_d  = cnt_q == 4'd1 ? FINAL : ROUND;
      end
      FINAL: begin
        o_d  = sr_sb;
        st_d = DONE;
      end
      default: st_d = IDLE;
    endcase
`ifdef AES_INV_CIPHER_ABORT_EN
    if (abort && st_q != IDLE) begin
      st_d  = IDLE;
      cnt_d = '0;
      s_d   = '0;
      o_d   = o_q;
    end
`endif
  end

`ifndef AES_INV_CIPHER_ABORT_EN
  logic unused_abort;
  assign unused_abort = abort;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= IDLE;
      cnt_q <= '0;
      s_q   <= '0;
      o_q   <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      s_q   <= s_d;
      o_q   <= o_d;
    end
  end
endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// tb_aes_inv_cipher_ctrl: directed FIPS-197 C.1 decryption vectors against aes_inv_cipher_ctrl.
module tb_aes_inv_cipher_ctrl;
  localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] JUNK = 128'hdeadbeef_cafef00d_01234567_89abcdef;
  localparam logic [127:0] RK [0:10] = '{
    128'h000102030405060708090a0b0c0d0e0f,
    128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe,
    128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd,
    128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b,
    128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2,
    128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5
  };

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, busy, abort;
  logic [127:0] in_data, out_data, rk_key;
  logic [3:0] rk_idx;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign rk_key = rk_idx <= 4'd10 ? RK[rk_idx] : '0;

  aes_inv_cipher_ctrl #(.NR(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rk_idx(rk_idx), .rk_key(rk_key), .busy(busy), .abort(abort)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic run_block(input logic [127:0] ct, input string tag);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = ct;
    n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_acc"}, in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, 10);
    chk({tag, "_pt"}, out_data, PT);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int n, nx, na;
    int xc [2];
    int ac [2];
    logic [127:0] xd [2];
    logic seen;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; abort = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_od", out_data, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rk", rk_idx, 4'd10);
    #9 rst = 1'b0;
    @(negedge clk);
    chk("idle_ir", in_ready, 1'b1);
    chk("idle_rk", rk_idx, 4'd10);
    in_valid = 1'b1;
    in_data  = CT;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("fips_rk%0d", k), rk_idx, k <= 8 ? 9 - k : (k == 9 ? 0 : 10));
      chk($sformatf("fips_ov%0d", k), out_valid, k == 10);
    end
    chk("fips_pt", out_data, PT);
    @(negedge clk);
    chk("fips_xfer", out_valid, 1'b0);
    chk("fips_ir", in_ready, 1'b1);
    // backpressure, with junk offered while busy
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = CT;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    in_data  = JUNK;
    chk("junk_ir", in_ready, 1'b0);
    chk("junk_busy", busy, 1'b1);
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_ov", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_od", out_data, PT);
      chk("bp_ir", in_ready, 1'b0);
      chk("bp_busy", busy, 1'b0);
      @(negedge clk);
    end
    chk("bp_hold", out_valid, 1'b1);
    out_ready = 1'b1;
    #1 chk("bp_ir_rdy", in_ready, 1'b1);
    @(negedge clk);
    chk("bp_xfer", out_valid, 1'b0);
    // back-to-back
    in_valid = 1'b1;
    in_data  = CT;
    nx = 0;
    na = 0;
    for (int i = 0; i < 40 && nx < 2; i++) begin
      if (na == 2) in_valid = 1'b0;
      if (in_valid && in_ready && na < 2) begin
        ac[na] = i;
        na++;
      end
      if (out_valid && out_ready) begin
        xd[nx] = out_data;
        xc[nx] = i;
        nx++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b_nx", nx, 2);
    chk("b2b_na", na, 2);
    chk("b2b_pt0", xd[0], PT);
    chk("b2b_pt1", xd[1], PT);
    chk("b2b_lat", xc[0] - ac[0], 11);
    chk("b2b_same_edge", ac[1], xc[0]);
    chk("b2b_gap", xc[1] - xc[0], 11);
    // async reset mid-round
    in_valid = 1'b1;
    in_data  = CT;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (rk_idx != 4'd5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ar_cnt5", rk_idx, 4'd5);
    #2 rst = 1'b1;
    #1;
    chk("ar_ov", out_valid, 1'b0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_rk", rk_idx, 4'd10);
    chk("ar_od", out_data, '0);
    #3 rst = 1'b0;
    run_block(CT, "ar");
    // abort at cnt 4
    in_valid = 1'b1;
    in_data  = CT;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (rk_idx != 4'd4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ab_cnt4", rk_idx, 4'd4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
`ifdef AES_INV_CIPHER_ABORT_EN
    chk("ab_busy", busy, 1'b0);
    chk("ab_rk", rk_idx, 4'd10);
    chk("ab_ir", in_ready, 1'b1);
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("ab_ov", seen, 1'b0);
`else
    seen = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ab_ov", out_valid, 1'b1);
    chk("ab_pt", out_data, PT);
`endif
    run_block(CT, "post");
    @(negedge clk);
    chk("end_ov", out_valid, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
